seg_demux: RTL

- Registered 1-to-N demultiplexer for 7-bit seven-segment codes; the distribution counterpart to the 2:1 segment selector used in the display path.
- Takes one stream of segment words with a valid/ready handshake and steers each word into one of N held display slots (HEX0..HEX5 on the board).
- Supports direct addressing, auto-increment addressing with wrap-around, and a multi-cycle clear sweep.
- Sits between display-producing logic and the HEX pins.

---
 rtl/seg_demux.sv | 78 +++++++
 1 files changed

// File: rtl/seg_demux.sv
// Registered 1-to-N demultiplexer that steers a valid/ready stream of 7-bit segment
// codes into N held display slots, with direct, auto-increment and clear-sweep modes.
//
// state | meaning
// IDLE  | accepting words; clear request starts a sweep
// CLEAR | blanking one slot per cycle, index 0..N-1
module seg_demux #(
  parameter int         N     = 6,
  parameter int         SELW  = 3,
  parameter logic [6:0] BLANK = 7'b1111111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_data,
  input  logic [SELW-1:0]     in_sel,
  input  logic                auto_inc,
  input  logic                clear,
  output logic                sel_err,
  output logic                busy,
  output logic [SELW-1:0]     wr_ptr,
  output logic [N-1:0][6:0]   hex_out
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  state_t          state;
  logic [SELW-1:0] clr_idx;
  logic            accept;

  assign in_ready = (state == IDLE) & ~clear;
  assign busy     = (state == CLEAR);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hex_out <= {N{BLANK}};
      wr_ptr  <= '0;
      sel_err <= 1'b0;
      clr_idx <= '0;
    end else begin
      sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (accept) begin
            if (auto_inc) begin
              hex_out[wr_ptr] <= in_data;
              wr_ptr          <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end else if (int'(in_sel) < N) begin
              hex_out[in_sel] <= in_data;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          hex_out[clr_idx] <= BLANK;
          // The sweep always ends with the auto pointer back at slot 0.
          if (clr_idx == LAST) begin
            state   <= IDLE;
            clr_idx <= '0;
            wr_ptr  <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
